pulse_rate_meter: RTL and testbench
===================================

Name: pulse_rate_meter

Overview:
Receive-side companion to the Poisson pulse generator: measures the pulse stream it produces on the DE0 board.
- Counts rising edges of a pulse input over a programmable gate window of clock cycles.
- Records the minimum and maximum inter-arrival gap within that window.
- Hands results to the host or readout logic through a valid/ack handshake. Runs single-shot or back-to-back continuous gates, so the generator's threshold settings can be checked for rate and timing in hardware.

Parameters:
SYNC_STAGES, 2, synchroniser flops on pulse_in (legal 0..3; 0 = input is already in the clk domain)
GATE_DEFAULT, 32'd50000000, reset value of gate length (1 s at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pulse_in  input  1  pulse stream under measurement
gate_len  input  32  gate length in clk cycles
gate_len_wr  input  1  load gate_len into internal gate register
start  input  1  one-cycle strobe: begin a gate when idle
continuous  input  1  level; when high at gate end, the next gate starts immediately
busy  output  1  high while a gate is open
count  output  32  edges counted in last completed gate
min_gap  output  32  smallest edge-to-edge gap (cycles) in last gate
max_gap  output  32  largest edge-to-edge gap (cycles) in last gate
saturated  output  1  count or a gap saturated in last gate
result_valid  output  1  new result available
result_ack  input  1  consumer acknowledges result
overrun  output  1  a result was overwritten before being acked

Behaviour:
- Reset (async assert, sync-released internally by clk edge): busy=0, count=0, min_gap=0, max_gap=0, saturated=0, result_valid=0, overrun=0, FSM=IDLE, gate register=GATE_DEFAULT.
- Edge detect: pulse_in passes through SYNC_STAGES flops, then one registered compare. Strobe edge_det is high for one cycle, SYNC_STAGES+1 cycles after the input rises. A pulse held high for N cycles counts once.
- Gate register:
  - Written on gate_len_wr. A value of 0 is stored as 1.
  - A write during a gate affects only the next gate; the length is captured at gate start.
- FSM is IDLE / COUNT.
  - IDLE: start=1 -> COUNT next cycle; busy=1 from that cycle. Gate cycle 0 is the first cycle with busy=1.
  - COUNT: runs exactly L cycles (gate cycles 0..L-1). start is ignored in COUNT. An edge_det in any gate cycle, including L-1, belongs to that gate.
  - End of gate (cycle L-1): results are latched and visible the next cycle.
  - Gate-end transition: continuous=1 -> stay in COUNT, new gate cycle 0 is the next cycle (zero dead time). Otherwise -> IDLE, busy=0.
- Count: increments per edge_det and saturates at 32'hFFFFFFFF, which sets the per-gate sat flag.
- Gap measurement:
  - Free counter: on edge_det it loads 1; otherwise it increments, saturating at all-ones.
  - On an edge that is not the first in the gate, the counter value before reload is the candidate gap. It updates the min/max accumulators.
  - Accumulators reset at every gate start (min = all-ones, max = 0). Gaps never span two gates.
  - Gate with <2 edges: min_gap=32'hFFFFFFFF, max_gap=0.
  - A saturated gap sets the sat flag.
- Handshake:
  - At result latch, result_valid=1.
  - result_ack with result_valid=1 clears result_valid next cycle.
  - Latch and ack in the same cycle: the new result wins and result_valid stays 1.
  - Latch while result_valid=1 and no ack sets overrun, sticky until the next accepted ack.
- Reset mid-gate aborts: all state returns to reset values, and partial results are discarded.

Decomposition:
- Package pulse_meter_pkg:
  - FSM state enum (IDLE, COUNT)
  - CNT_W=32
  - ALL_ONES constant
  - GATE_DEFAULT default
- Sub-module pulse_edge_sync: parameterised synchroniser plus rising-edge strobe (pulse_in -> edge_det). All other logic stays in pulse_rate_meter.

Test Plan:
- gate_len=100, start; 1-cycle edges landing in gate cycles 5,15,...,95 -> count=10, min_gap=10, max_gap=10, result_valid=1 the cycle after gate cycle 99, saturated=0.
- gate_len=100; pulse_in held high 50 cycles -> count=1, min_gap=32'hFFFFFFFF, max_gap=0.
- continuous=1, gate_len=20; edges in gate cycles 19 and next gate's 0 -> each gate reports count=1; no gap of 1 recorded; busy never drops.
- continuous=1, never ack two gates -> overrun=1, outputs show second gate's values; ack -> result_valid=0 next cycle, overrun=0.
- gate_len_wr 50 during a 100-cycle gate -> current gate lasts 100 cycles, next gate lasts 50. gate_len=0 -> gate lasts 1 cycle.
- rst_n low in gate cycle 40 -> outputs immediately at reset values, busy=0. start after release -> normal gate with fresh results.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// ---------------------------------------------------------------------------
// pulse_meter_pkg
// Shared types and constants for the pulse rate meter.
//   state_t      : gate FSM states (IDLE, COUNT)
//   CNT_W        : width of every counter, gap and length value
//   ALL_ONES     : saturation value for CNT_W-wide counters
//   GATE_DEFAULT : gate length after reset (1 s at 50 MHz)
//   sat_inc()    : increment that sticks at ALL_ONES
// ---------------------------------------------------------------------------
package pulse_meter_pkg;

    localparam int CNT_W = 32;

    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

    localparam logic [CNT_W-1:0] GATE_DEFAULT = 32'd50000000;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == ALL_ONES) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pulse_rate_meter_if.sv
// ---------------------------------------------------------------------------
// pulse_rate_meter_if
// Result handshake between the meter and its consumer (host or readout).
//   count, min_gap, max_gap, saturated : results of the last completed gate
//   result_valid                       : a new result is waiting
//   result_ack                         : consumer has taken the result
//   overrun                            : a result was overwritten unacked
// Modports: master = meter side, slave = consumer side.
// ---------------------------------------------------------------------------
interface pulse_rate_meter_if;
    import pulse_meter_pkg::*;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] min_gap;
    logic [CNT_W-1:0] max_gap;
    logic             saturated;
    logic             result_valid;
    logic             result_ack;
    logic             overrun;

    modport master (
        output count,
        output min_gap,
        output max_gap,
        output saturated,
        output result_valid,
        output overrun,
        input  result_ack
    );

    modport slave (
        input  count,
        input  min_gap,
        input  max_gap,
        input  saturated,
        input  result_valid,
        input  overrun,
        output result_ack
    );

endinterface

// File: rtl/pulse_edge_sync.sv
// ---------------------------------------------------------------------------
// pulse_edge_sync
// Brings pulse_in into the clk domain through SYNC_STAGES flops and emits a
// one-cycle strobe on each rising edge of the synchronised level. The strobe
// appears SYNC_STAGES+1 cycles after the input rises; a long high level
// produces a single strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   pulse_in   : raw pulse stream
//   edge_det   : registered rising-edge strobe
// ---------------------------------------------------------------------------
module pulse_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic edge_det
);

    logic synced;
    logic synced_prev;

    // SYNC_STAGES = 0 means the source already lives in the clk domain.
    if (SYNC_STAGES == 0) begin : g_direct
        assign synced = pulse_in;
    end else begin : g_chain
        logic [SYNC_STAGES-1:0] chain;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain <= '0;
            end else begin
                chain[0] <= pulse_in;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    chain[i] <= chain[i-1];
                end
            end
        end

        assign synced = chain[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced_prev <= 1'b0;
            edge_det    <= 1'b0;
        end else begin
            synced_prev <= synced;
            edge_det    <= synced & ~synced_prev;
        end
    end

endmodule

// File: rtl/pulse_rate_meter.sv
// ---------------------------------------------------------------------------
// pulse_rate_meter
// Counts rising edges of pulse_in over a gate of L clk cycles and records
// the smallest and largest edge-to-edge gap inside that gate. Results are
// handed over through a valid/ack handshake; gates run single-shot or
// back-to-back with zero dead time.
//   clk, rst_n   : clock, asynchronous active-low reset
//   pulse_in     : pulse stream under measurement
//   gate_len     : gate length in cycles, loaded on gate_len_wr (0 -> 1)
//   gate_len_wr  : load strobe for gate_len
//   start        : begin a gate when idle
//   continuous   : at gate end, start the next gate immediately
//   busy         : a gate is open
//   res          : result handshake (see pulse_rate_meter_if)
// ---------------------------------------------------------------------------
module pulse_rate_meter #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [31:0] GATE_DEFAULT = pulse_meter_pkg::GATE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pulse_in,
    input  logic [31:0] gate_len,
    input  logic        gate_len_wr,
    input  logic        start,
    input  logic        continuous,
    output logic        busy,
    pulse_rate_meter_if.master res
);
    import pulse_meter_pkg::*;

    state_t state_q;
    state_t state_d;

    logic             edge_det;
    logic             gate_start;
    logic             gate_end;

    logic [CNT_W-1:0] gate_reg;
    logic [CNT_W-1:0] cur_len;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] gap_cnt;

    logic [CNT_W-1:0] acc_count;
    logic [CNT_W-1:0] acc_min;
    logic [CNT_W-1:0] acc_max;
    logic             acc_sat;

    logic [CNT_W-1:0] upd_count;
    logic [CNT_W-1:0] upd_min;
    logic [CNT_W-1:0] upd_max;
    logic             upd_sat;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic             r_sat;
    logic             r_valid;
    logic             r_overrun;

    pulse_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .edge_det (edge_det)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Gate end in continuous mode is also a gate start, so the new gate's
    // cycle 0 immediately follows the old gate's last cycle.
    always_comb begin
        state_d    = state_q;
        gate_start = 1'b0;
        gate_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = COUNT;
                    gate_start = 1'b1;
                end
            end
            COUNT: begin
                if (cyc == cur_len - 1'b1) begin
                    gate_end = 1'b1;
                    if (continuous) begin
                        gate_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator values including this cycle's edge, so an edge in the last
    // gate cycle still lands in the latched result. A non-zero count means an
    // earlier edge exists in this gate and gap_cnt is a valid gap.
    always_comb begin
        upd_count = acc_count;
        upd_min   = acc_min;
        upd_max   = acc_max;
        upd_sat   = acc_sat;
        if (edge_det) begin
            if (acc_count == ALL_ONES) begin
                upd_sat = 1'b1;
            end else begin
                upd_count = acc_count + 1'b1;
            end
            if (acc_count != '0) begin
                if (gap_cnt == ALL_ONES) begin
                    upd_sat = 1'b1;
                end
                if (gap_cnt < acc_min) begin
                    upd_min = gap_cnt;
                end
                if (gap_cnt > acc_max) begin
                    upd_max = gap_cnt;
                end
            end
        end
    end

    // Zero would mean an endless gate, so it is stored as the shortest one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_reg <= GATE_DEFAULT;
        end else if (gate_len_wr) begin
            gate_reg <= (gate_len == '0) ? 32'd1 : gate_len;
        end
    end

    // The length is captured at gate start so mid-gate writes only affect
    // the following gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_len <= 32'd1;
            cyc     <= '0;
        end else if (gate_start) begin
            cur_len <= gate_reg;
            cyc     <= '0;
        end else if (state_q == COUNT) begin
            cyc <= cyc + 1'b1;
        end
    end

    // Free-running gap counter: holds the cycles elapsed since the last edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (edge_det) begin
            gap_cnt <= 32'd1;
        end else begin
            gap_cnt <= sat_inc(gap_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_count <= '0;
            acc_min   <= ALL_ONES;
            acc_max   <= '0;
            acc_sat   <= 1'b0;
        end else if (gate_start) begin
            acc_count <= '0;
            acc_min   <= ALL_ONES;
            acc_max   <= '0;
            acc_sat   <= 1'b0;
        end else if (state_q == COUNT) begin
            acc_count <= upd_count;
            acc_min   <= upd_min;
            acc_max   <= upd_max;
            acc_sat   <= upd_sat;
        end
    end

    // A latch coinciding with an ack replaces the acked result, so valid
    // stays high and no overrun is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_sat     <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (gate_end) begin
            r_count <= upd_count;
            r_min   <= upd_min;
            r_max   <= upd_max;
            r_sat   <= upd_sat;
            r_valid <= 1'b1;
            if (r_valid && !res.result_ack) begin
                r_overrun <= 1'b1;
            end else if (r_valid && res.result_ack) begin
                r_overrun <= 1'b0;
            end
        end else if (r_valid && res.result_ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign busy             = (state_q == COUNT);
    assign res.count        = r_count;
    assign res.min_gap      = r_min;
    assign res.max_gap      = r_max;
    assign res.saturated    = r_sat;
    assign res.result_valid = r_valid;
    assign res.overrun      = r_overrun;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// ---------------------------------------------------------------------------
// tb_pulse_rate_meter
// Directed bench for pulse_rate_meter with SYNC_STAGES = 2. Inputs change
// 1 time unit after each rising clk edge and outputs are read at that same
// point, so a pulse_in raised in gate cycle c produces an edge in gate
// cycle c+3.
// ---------------------------------------------------------------------------
module tb_pulse_rate_meter;

    logic        clk;
    logic        rst_n;
    logic        pulse_in;
    logic [31:0] gate_len;
    logic        gate_len_wr;
    logic        start;
    logic        continuous;
    logic        busy;

    int n_checks;
    int n_fail;

    pulse_rate_meter_if res_if ();

    pulse_rate_meter #(
        .SYNC_STAGES  (2),
        .GATE_DEFAULT (32'd50000000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pulse_in    (pulse_in),
        .gate_len    (gate_len),
        .gate_len_wr (gate_len_wr),
        .start       (start),
        .continuous  (continuous),
        .busy        (busy),
        .res         (res_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads a gate length, then pulses start; returns in gate cycle 0.
    task automatic begin_gate(input logic [31:0] len);
        gate_len    = len;
        gate_len_wr = 1'b1;
        tick();
        gate_len_wr = 1'b0;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic ack_result();
        res_if.result_ack = 1'b1;
        tick();
        res_if.result_ack = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: got %0b expected 0", busy);
        end
        n_checks++;
        if (res_if.count !== 32'd0 || res_if.min_gap !== 32'd0 || res_if.max_gap !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_results: got count=%0h min=%0h max=%0h expected 0/0/0",
                     res_if.count, res_if.min_gap, res_if.max_gap);
        end
        n_checks++;
        if (res_if.result_valid !== 1'b0 || res_if.overrun !== 1'b0 || res_if.saturated !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got valid=%0b overrun=%0b sat=%0b expected 0/0/0",
                     res_if.result_valid, res_if.overrun, res_if.saturated);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Edges in gate cycles 5,15,...,95 of a 100-cycle gate.
    task automatic test_basic();
        begin_gate(32'd100);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL basic_busy_cycle0: got %0b expected 1", busy);
        end
        for (int c = 0; c < 100; c++) begin
            pulse_in = (c >= 2 && c <= 92 && (c - 2) % 10 == 0);
            if (c == 99) begin
                n_checks++;
                if (res_if.result_valid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL basic_valid_early: got %0b expected 0", res_if.result_valid);
                end
            end
            tick();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (res_if.result_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_valid_end: got valid=%0b busy=%0b expected 1/0",
                     res_if.result_valid, busy);
        end
        n_checks++;
        if (res_if.count !== 32'd10 || res_if.min_gap !== 32'd10 || res_if.max_gap !== 32'd10) begin
            n_fail++;
            $display("[TB] FAIL basic_values: got count=%0d min=%0d max=%0d expected 10/10/10",
                     res_if.count, res_if.min_gap, res_if.max_gap);
        end
        n_checks++;
        if (res_if.saturated !== 1'b0 || res_if.overrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_flags: got sat=%0b overrun=%0b expected 0/0",
                     res_if.saturated, res_if.overrun);
        end
        ack_result();
        n_checks++;
        if (res_if.result_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_ack: got valid=%0b expected 0", res_if.result_valid);
        end
    endtask

    // pulse_in high for gate cycles 0..49 gives a single edge.
    task automatic test_held_pulse();
        begin_gate(32'd100);
        for (int c = 0; c < 100; c++) begin
            pulse_in = (c < 50);
            tick();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (res_if.count !== 32'd1 || res_if.min_gap !== 32'hFFFFFFFF || res_if.max_gap !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL held_values: got count=%0d min=%0h max=%0h expected 1/ffffffff/0",
                     res_if.count, res_if.min_gap, res_if.max_gap);
        end
        ack_result();
    endtask

    // Two 20-cycle gates: edge in gate A cycle 19, edge in gate B cycle 1.
    // The 2-cycle spacing across the boundary must not become a gap.
    task automatic test_back_to_back();
        logic busy_held;
        busy_held  = 1'b1;
        continuous = 1'b1;
        begin_gate(32'd20);
        for (int c = 0; c < 40; c++) begin
            pulse_in = (c == 16 || c == 18);
            if (c == 30) continuous = 1'b0;
            if (busy !== 1'b1) busy_held = 1'b0;
            if (c == 20) begin
                n_checks++;
                if (res_if.result_valid !== 1'b1 || res_if.count !== 32'd1) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_gate_a: got valid=%0b count=%0d expected 1/1",
                             res_if.result_valid, res_if.count);
                end
                n_checks++;
                if (res_if.min_gap !== 32'hFFFFFFFF || res_if.max_gap !== 32'd0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_gate_a_gaps: got min=%0h max=%0h expected ffffffff/0",
                             res_if.min_gap, res_if.max_gap);
                end
                res_if.result_ack = 1'b1;
            end
            if (c == 21) begin
                res_if.result_ack = 1'b0;
                n_checks++;
                if (res_if.result_valid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_ack_mid_gate: got valid=%0b expected 0", res_if.result_valid);
                end
            end
            tick();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (busy_held !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_busy_held: got %0b expected 1", busy_held);
        end
        n_checks++;
        if (busy !== 1'b0 || res_if.result_valid !== 1'b1 || res_if.count !== 32'd1) begin
            n_fail++;
            $display("[TB] FAIL b2b_gate_b: got busy=%0b valid=%0b count=%0d expected 0/1/1",
                     busy, res_if.result_valid, res_if.count);
        end
        n_checks++;
        if (res_if.min_gap !== 32'hFFFFFFFF || res_if.max_gap !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL b2b_gate_b_gaps: got min=%0h max=%0h expected ffffffff/0",
                     res_if.min_gap, res_if.max_gap);
        end
        ack_result();
    endtask

    // Gate A: one edge (cycle 5). Gate B: edges at cycles 5 and 12, no ack.
    task automatic test_overrun();
        continuous = 1'b1;
        begin_gate(32'd20);
        for (int c = 0; c < 40; c++) begin
            pulse_in = (c == 2 || c == 22 || c == 29);
            if (c == 30) continuous = 1'b0;
            if (c == 20) begin
                n_checks++;
                if (res_if.result_valid !== 1'b1 || res_if.overrun !== 1'b0 || res_if.count !== 32'd1) begin
                    n_fail++;
                    $display("[TB] FAIL ovr_first: got valid=%0b overrun=%0b count=%0d expected 1/0/1",
                             res_if.result_valid, res_if.overrun, res_if.count);
                end
            end
            tick();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (res_if.overrun !== 1'b1 || res_if.result_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovr_set: got overrun=%0b valid=%0b expected 1/1",
                     res_if.overrun, res_if.result_valid);
        end
        n_checks++;
        if (res_if.count !== 32'd2 || res_if.min_gap !== 32'd7 || res_if.max_gap !== 32'd7) begin
            n_fail++;
            $display("[TB] FAIL ovr_values: got count=%0d min=%0d max=%0d expected 2/7/7",
                     res_if.count, res_if.min_gap, res_if.max_gap);
        end
        ack_result();
        n_checks++;
        if (res_if.overrun !== 1'b0 || res_if.result_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ovr_clear: got overrun=%0b valid=%0b expected 0/0",
                     res_if.overrun, res_if.result_valid);
        end
    endtask

    // Write 50 during a 100-cycle gate: this gate stays 100, the next is 50.
    // Then a zero length runs a single-cycle gate.
    task automatic test_gate_write();
        continuous = 1'b1;
        begin_gate(32'd100);
        for (int c = 0; c < 150; c++) begin
            gate_len_wr = (c == 10);
            if (c == 10) gate_len = 32'd50;
            if (c == 120) continuous = 1'b0;
            if (c == 99) begin
                n_checks++;
                if (res_if.result_valid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL gw_first_early: got valid=%0b expected 0", res_if.result_valid);
                end
            end
            if (c == 100) begin
                n_checks++;
                if (res_if.result_valid !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL gw_first_end: got valid=%0b busy=%0b expected 1/1",
                             res_if.result_valid, busy);
                end
                res_if.result_ack = 1'b1;
            end
            if (c == 101) res_if.result_ack = 1'b0;
            if (c == 149) begin
                n_checks++;
                if (res_if.result_valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL gw_second_early: got valid=%0b busy=%0b expected 0/1",
                             res_if.result_valid, busy);
                end
            end
            tick();
        end
        gate_len_wr = 1'b0;
        n_checks++;
        if (res_if.result_valid !== 1'b1 || busy !== 1'b0 || res_if.count !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL gw_second_end: got valid=%0b busy=%0b count=%0d expected 1/0/0",
                     res_if.result_valid, busy, res_if.count);
        end
        ack_result();

        begin_gate(32'd0);
        n_checks++;
        if (busy !== 1'b1 || res_if.result_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gw_zero_cycle0: got busy=%0b valid=%0b expected 1/0",
                     busy, res_if.result_valid);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || res_if.result_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL gw_zero_end: got busy=%0b valid=%0b expected 0/1",
                     busy, res_if.result_valid);
        end
    endtask

    // Enters with an unacked result (min_gap all-ones) and aborts a gate
    // at cycle 40; a fresh gate afterwards must not report an overrun.
    task automatic test_reset_mid_gate();
        begin_gate(32'd100);
        for (int c = 0; c < 40; c++) begin
            pulse_in = (c == 2);
            tick();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || res_if.result_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_pre: got busy=%0b valid=%0b expected 1/1", busy, res_if.result_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || res_if.result_valid !== 1'b0 || res_if.overrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_async_flags: got busy=%0b valid=%0b overrun=%0b expected 0/0/0",
                     busy, res_if.result_valid, res_if.overrun);
        end
        n_checks++;
        if (res_if.count !== 32'd0 || res_if.min_gap !== 32'd0 || res_if.max_gap !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_async_values: got count=%0h min=%0h max=%0h expected 0/0/0",
                     res_if.count, res_if.min_gap, res_if.max_gap);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        begin_gate(32'd30);
        for (int c = 0; c < 30; c++) begin
            pulse_in = (c == 2 || c == 12);
            tick();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (res_if.result_valid !== 1'b1 || res_if.overrun !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_fresh_flags: got valid=%0b overrun=%0b busy=%0b expected 1/0/0",
                     res_if.result_valid, res_if.overrun, busy);
        end
        n_checks++;
        if (res_if.count !== 32'd2 || res_if.min_gap !== 32'd10 || res_if.max_gap !== 32'd10) begin
            n_fail++;
            $display("[TB] FAIL rst_fresh_values: got count=%0d min=%0d max=%0d expected 2/10/10",
                     res_if.count, res_if.min_gap, res_if.max_gap);
        end
        ack_result();
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        pulse_in          = 1'b0;
        gate_len          = 32'd0;
        gate_len_wr       = 1'b0;
        start             = 1'b0;
        continuous        = 1'b0;
        res_if.result_ack = 1'b0;

        test_reset();
        test_basic();
        test_held_pulse();
        test_back_to_back();
        test_overrun();
        test_gate_write();
        test_reset_mid_gate();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
